// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser above a UART receiver: SOF, LEN, payload, CHK; releases verified payloads on a valid/ready stream.
// Optional inter-byte timeout is compiled in with `define UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_en,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    input  logic       pl_ready,
    output logic       pl_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] idx;
    logic [7:0] rd_ptr;
    logic [7:0] buf_mem [MAX_LEN];

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [GW-1:0] gap_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign busy = (state != ST_HUNT);

    // Payload storage has no reset: contents are only read after being written by the current frame.
    always_ff @(posedge clk) begin
        if (ena && rx_valid && state == ST_PAYLOAD)
            buf_mem[idx[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            rx_en     <= 1'b0;
            pl_data   <= 8'd0;
            pl_valid  <= 1'b0;
            pl_last   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            len       <= 8'd0;
            sum       <= 8'd0;
            idx       <= 8'd0;
            rd_ptr    <= 8'd0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
            gap_cnt   <= '0;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            rx_en     <= ena;
`ifdef UART_RX_FRAME_TIMEOUT_EN
            gap_cnt   <= '0;
`endif
            if (!ena) begin
                // Silent abort: drop the frame without reporting an error.
                state    <= ST_HUNT;
                pl_valid <= 1'b0;
                pl_last  <= 1'b0;
                sum      <= 8'd0;
                idx      <= 8'd0;
                rd_ptr   <= 8'd0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (rx_valid && rx_data == SOF_BYTE)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b01;
                                state     <= ST_HUNT;
                            end else begin
                                len   <= rx_data;
                                sum   <= rx_data;
                                idx   <= 8'd0;
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
                            sum <= sum + rx_data;
                            idx <= idx + 8'd1;
                            if (8'(idx + 8'd1) == len)
                                state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (rx_valid) begin
                            if (8'(sum + rx_data) == 8'd0) begin
                                state    <= ST_DRAIN;
                                rd_ptr   <= 8'd0;
                                pl_valid <= 1'b1;
                                pl_data  <= buf_mem[0];
                                pl_last  <= (len == 8'd1);
                                frame_ok <= 1'b1;
                                rx_en    <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b10;
                                state     <= ST_HUNT;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        rx_en <= 1'b0;
                        if (pl_ready) begin
                            if (8'(rd_ptr + 8'd1) == len) begin
                                pl_valid <= 1'b0;
                                pl_last  <= 1'b0;
                                state    <= ST_HUNT;
                                rx_en    <= 1'b1;
                            end else begin
                                rd_ptr  <= rd_ptr + 8'd1;
                                pl_data <= buf_mem[AW'(rd_ptr + 8'd1)];
                                pl_last <= (8'(rd_ptr + 8'd2) == len);
                            end
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
`ifdef UART_RX_FRAME_TIMEOUT_EN
                // Gap counter only runs mid-frame while waiting for the next byte.
                if (!rx_valid && (state == ST_LEN || state == ST_PAYLOAD || state == ST_CHECK)) begin
                    if (gap_cnt == GW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        state     <= ST_HUNT;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frame scenarios plus a randomized byte stream
// checked against a frame-level parsing model.
module tb_uart_rx_frame_ctrl;
    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         TO      = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       pl_ready = 1'b0;
    logic       rx_en, pl_valid, pl_last, frame_ok, frame_err, busy;
    logic [7:0] pl_data;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [1:0] exp_err_q[$];
    logic [1:0] got_err_q[$];
    logic [7:0] stream_q[$];
    int         exp_ok = 0;
    int         got_ok = 0;
    bit         rdy_rand = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .MAX_LEN(MAX_LEN), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_en(rx_en), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .pl_last(pl_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) pl_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: collects handshakes and status pulses, and checks hold-while-stalled.
    logic       prev_stall = 1'b0;
    logic       prev_ena = 1'b0;
    logic [8:0] prev_word = 9'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && prev_ena) begin
                check("hold_valid", pl_valid, 1);
                check("hold_word", {pl_last, pl_data}, prev_word);
            end
            if (pl_valid && pl_ready) got_q.push_back({pl_last, pl_data});
            if (frame_ok) got_ok++;
            if (frame_err) got_err_q.push_back(err_code);
            prev_stall = pl_valid && !pl_ready;
            prev_word  = {pl_last, pl_data};
            prev_ena   = ena;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        while (!rx_en && n < 500) begin
            tick();
            n++;
        end
        check("rx_en_ready", rx_en, 1);
        rx_data  = b;
        rx_valid = 1'b1;
        stream_q.push_back(b);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick(gap);
    endtask

    // kind: 0 good, 1 bad checksum
    task automatic send_frame(input int len, input int kind, input int max_gap);
        logic [7:0] pl[$];
        logic [7:0] total;
        total = 8'(len);
        for (int k = 0; k < len; k++) begin
            pl.push_back(8'($urandom));
            total = total + pl[k];
        end
        send_byte(SOF, $urandom_range(0, max_gap));
        send_byte(8'(len), $urandom_range(0, max_gap));
        foreach (pl[k]) send_byte(pl[k], $urandom_range(0, max_gap));
        if (kind == 0) send_byte(8'(0) - total, 0);
        else send_byte(8'(0) - total + 8'($urandom_range(1, 255)), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 0);
        tick(2);
    endtask

    task automatic clear_all();
        got_q.delete(); exp_q.delete(); got_err_q.delete(); exp_err_q.delete();
        stream_q.delete(); got_ok = 0; exp_ok = 0;
    endtask

    // Frame-level reading of the byte stream: hunt SOF, validate LEN, sum the frame.
    task automatic run_model();
        int i;
        int len;
        int total;
        exp_q.delete(); exp_err_q.delete(); exp_ok = 0;
        i = 0;
        while (i < stream_q.size()) begin
            if (stream_q[i] != SOF) begin
                i++;
                continue;
            end
            if (i + 1 >= stream_q.size()) break;
            len = int'(stream_q[i+1]);
            i += 2;
            if (len == 0 || len > MAX_LEN) begin
                exp_err_q.push_back(2'b01);
                continue;
            end
            if (i + len >= stream_q.size()) break;
            total = len;
            for (int k = 0; k <= len; k++) total += int'(stream_q[i+k]);
            if (total % 256 == 0) begin
                for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), stream_q[i+k]});
                exp_ok++;
            end else begin
                exp_err_q.push_back(2'b10);
            end
            i += len + 1;
        end
    endtask

    task automatic compare_results(input string name);
        run_model();
        check({name, "_n_payload"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_payload[%0d]", name, i), got_q[i], exp_q[i]);
        check({name, "_n_ok"}, got_ok, exp_ok);
        check({name, "_n_err"}, got_err_q.size(), exp_err_q.size());
        for (int i = 0; i < got_err_q.size() && i < exp_err_q.size(); i++)
            check($sformatf("%s_err[%0d]", name, i), got_err_q[i], exp_err_q[i]);
        clear_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes[$];
        int         pat[5] = '{1, 0, 0, 1, 1};
        int         r;

        // Reset values
        tick(2);
        check("rst_rx_en", rx_en, 0);
        check("rst_pl_data", pl_data, 0);
        check("rst_pl_valid", pl_valid, 0);
        check("rst_pl_last", pl_last, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);
        check("rx_en_ena_low", rx_en, 0);
        ena = 1'b1;
        check("rx_en_lag", rx_en, 0);
        tick();
        check("rx_en_rise", rx_en, 1);

        // Good frame, back-to-back bytes, pl_ready held high
        pl_ready = 1'b1;
        bytes = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        foreach (bytes[k]) send_byte(bytes[k], 0);
        check("good_frame_ok", frame_ok, 1);
        check("good_valid0", pl_valid, 1);
        check("good_data0", pl_data, 8'h11);
        check("good_last0", pl_last, 0);
        check("good_rx_en0", rx_en, 0);
        tick();
        check("good_ok_pulse", frame_ok, 0);
        check("good_data1", {pl_valid, pl_last, pl_data}, {2'b10, 8'h22});
        tick();
        check("good_data2", {pl_valid, pl_last, pl_data}, {2'b11, 8'h33});
        tick();
        check("good_done_valid", pl_valid, 0);
        check("good_done_busy", busy, 0);
        check("good_done_rx_en", rx_en, 1);
        compare_results("good");

        // Backpressure
        pl_ready = 1'b0;
        foreach (bytes[k]) send_byte(bytes[k], 0);
        for (int i = 0; i < 5; i++) begin
            pl_ready = pat[i][0];
            check($sformatf("bp_valid%0d", i), pl_valid, 1);
            check($sformatf("bp_rx_en%0d", i), rx_en, 0);
            tick();
        end
        check("bp_done_valid", pl_valid, 0);
        check("bp_done_rx_en", rx_en, 1);
        compare_results("backpressure");

        // Checksum error followed by a good one-byte frame
        pl_ready = 1'b1;
        bytes = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        foreach (bytes[k]) send_byte(bytes[k], 0);
        check("chk_err_pulse", frame_err, 1);
        check("chk_err_code", err_code, 2'b10);
        check("chk_no_valid", pl_valid, 0);
        tick();
        check("chk_err_one_cycle", frame_err, 0);
        check("chk_err_code_held", err_code, 2'b10);
        bytes = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
        foreach (bytes[k]) send_byte(bytes[k], 0);
        check("one_byte_last", {pl_valid, pl_last, pl_data}, {2'b11, 8'h5A});
        wait_idle();
        compare_results("chk_err");

        // Bad length with leading garbage; MAX_LEN itself is accepted
        bytes = '{8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h00};
        foreach (bytes[k]) send_byte(bytes[k], 0);
        check("len0_err", frame_err, 1);
        check("len0_code", err_code, 2'b01);
        send_byte(SOF, 0);
        send_byte(8'h11, 0);
        check("len17_err", frame_err, 1);
        check("len17_code", err_code, 2'b01);
        send_frame(MAX_LEN, 0, 0);
        check("len_max_ok", frame_ok, 1);
        wait_idle();
        compare_results("bad_len");

        // Inter-byte gap
        bytes = '{8'hA5, 8'h02, 8'h10};
        foreach (bytes[k]) send_byte(bytes[k], 0);
`ifdef UART_RX_FRAME_TIMEOUT_EN
        tick(TO - 1);
        check("to_not_yet", frame_err, 0);
        tick();
        check("to_err", frame_err, 1);
        check("to_code", err_code, 2'b11);
        check("to_busy", busy, 0);
        tick();
        check("to_n_err", got_err_q.size(), 1);
        clear_all();
`else
        tick(TO);
        check("no_to_err", frame_err, 0);
        check("no_to_busy", busy, 1);
        send_byte(8'h20, 0);
        send_byte(8'hCE, 0);
        check("no_to_ok", frame_ok, 1);
        wait_idle();
        compare_results("no_timeout");
`endif

        // Abort mid-payload
        bytes = '{8'hA5, 8'h04, 8'h01, 8'h02};
        foreach (bytes[k]) send_byte(bytes[k], 0);
        check("abort_pre_busy", busy, 1);
        ena = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_rx_en", rx_en, 0);
        check("abort_no_err", frame_err, 0);
        check("abort_valid", pl_valid, 0);
        tick();
        check("abort_n_err", got_err_q.size(), 0);
        ena = 1'b1;
        tick();
        clear_all();
        send_frame(3, 0, 1);
        wait_idle();
        compare_results("after_abort");

        // Asynchronous reset mid-drain
        pl_ready = 1'b0;
        send_frame(4, 0, 0);
        tick(2);
        check("pre_rst_valid", pl_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_en", rx_en, 0);
        check("mid_rst_pl_data", pl_data, 0);
        check("mid_rst_pl_valid", pl_valid, 0);
        check("mid_rst_pl_last", pl_last, 0);
        check("mid_rst_frame_ok", frame_ok, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_err_code", err_code, 0);
        check("mid_rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_all();

        // Randomized stream with random backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                send_frame($urandom_range(1, MAX_LEN), 0, 2);
            end else if (r == 6) begin
                send_frame($urandom_range(1, MAX_LEN), 1, 2);
            end else if (r == 7) begin
                send_byte(SOF, $urandom_range(0, 2));
                send_byte(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)),
                          $urandom_range(0, 2));
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    logic [7:0] g;
                    g = 8'($urandom);
                    if (g == SOF) g = 8'h00;
                    send_byte(g, $urandom_range(0, 2));
                end
            end
        end
        wait_idle();
        rdy_rand = 1'b0;
        compare_results("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
